// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter sharing one combinational ROM port between instruction fetch and load/store.
// Optional address window checking (if_err/ls_err) is enabled by defining ROM_BUS_ARB_RANGE_CHECK_EN.
module rom_bus_arbiter #(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] ROM_START = '0,
  parameter int                ROM_SIZE  = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
  output logic              if_err,
  output logic              ls_err,
`endif
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HWRITE,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_ls_q, last_ls_d;   // 1 = LS was granted last
  logic              owner_q, owner_d;       // 1 = LS owns the current transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              grant_ls;
  logic [ADDR_W-1:0] grant_addr;

  // A tie goes to whoever did not win last time.
  assign grant_ls   = ls_req && (!if_req || !last_ls_q);
  assign grant_addr = grant_ls ? ls_addr : if_addr;

`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] ROM_LAST = ROM_START + ADDR_W'(ROM_SIZE - 5);
  logic err_q, err_d;
  logic grant_in_range;
  assign grant_in_range = (grant_addr >= ROM_START) && (grant_addr <= ROM_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    last_ls_d  = last_ls_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          owner_d   = grant_ls;
          last_ls_d = grant_ls;
          addr_d    = grant_addr;
          write_d   = grant_ls && ls_write;
          wdata_d   = grant_ls ? ls_wdata : '0;
          state_d   = ST_ACCESS;
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
          err_d = 1'b0;
          if (!grant_in_range) begin
            // Illegal address: never touch memory, answer with an error instead.
            err_d   = 1'b1;
            write_d = 1'b0;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          if (owner_q) ls_rdata_d = HRDATA;
          else         if_rdata_d = HRDATA;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      last_ls_q  <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Bus outputs are gated by state so they are quiet everywhere except ACCESS.
  assign HADDR    = (state_q == ST_ACCESS) ? addr_q : '0;
  assign HWRITE   = (state_q == ST_ACCESS) && write_q;
  assign HWDATA   = HWRITE ? wdata_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign if_ready = (state_q == ST_RESP) && !owner_q;
  assign ls_ready = (state_q == ST_RESP) && owner_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
`ifdef ROM_BUS_ARB_RANGE_CHECK_EN
  assign if_err   = if_ready && err_q;
  assign ls_err   = ls_ready && err_q;
`endif

endmodule

// File: doc/rom_bus_arbiter.md
Name: rom_bus_arbiter

Overview:
- Shares the single combinational instruction-ROM bus port (HADDR/HWDATA/HWRITE/HRDATA) between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Runs round-robin arbitration and registers the accepted request.
- Drives exactly one clean memory access per transaction and returns registered read data with a one-cycle ready pulse.
- Sits between the core front-end/LSU and the ROM.

Parameters:
ADDR_W, 64, width of all address buses
DATA_W, 64, width of all data buses
ROM_START, 64'h0, base address of the ROM window; used only by the range check
ROM_SIZE, 256, ROM window size in bytes; legal addresses are ROM_START to ROM_START+ROM_SIZE-5 inclusive

Ports:
HCLK  input  1  clock, all state on rising edge
HRESET  input  1  synchronous active-high reset
if_req  input  1  IF request, held until if_ready
if_addr  input  ADDR_W  IF read address
if_ready  output  1  one-cycle pulse: transaction done, if_rdata valid
if_rdata  output  DATA_W  IF read data, registered
ls_req  input  1  LS request, held until ls_ready
ls_write  input  1  1 = write, 0 = read
ls_addr  input  ADDR_W  LS address
ls_wdata  input  DATA_W  LS write data; low 32 bits are stored
ls_ready  output  1  one-cycle pulse: transaction done
ls_rdata  output  DATA_W  LS read data, registered; unchanged on writes
HADDR  output  ADDR_W  memory address
HWDATA  output  DATA_W  memory write data
HWRITE  output  1  memory write enable
HRDATA  input  DATA_W  memory combinational read data
busy  output  1  high in ACCESS and RESP states

Behaviour:
- One clock, HCLK. Reset is synchronous and active-high on HRESET.
- Reset values:
  - state = IDLE; last_grant = IF.
  - if_ready, ls_ready, HWRITE, busy = 0.
  - HADDR, HWDATA, if_rdata, ls_rdata = 0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles, with no back-to-back overlap.
- IDLE:
  - Sample if_req and ls_req.
  - Only one request: grant it.
  - Both requests: grant the requester not equal to last_grant, then update last_grant.
  - On grant, latch owner, address, write flag (forced 0 for IF) and write data into internal registers, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - HADDR = latched address.
  - HWRITE = latched write flag.
  - HWDATA = latched wdata if writing, else 0.
  - On the rising edge that exits ACCESS, capture HRDATA into the owner's rdata register if the access is a read.
  - Go to RESP.
- RESP:
  - The owner's ready = 1 for exactly this cycle; the other ready stays 0.
  - HWRITE = 0, HADDR = 0, HWDATA = 0.
  - req is not sampled in RESP. The requester drops req or presents a new request by the following IDLE cycle.
  - Go to IDLE.
- Outside ACCESS, HWRITE, HADDR and HWDATA are 0. HWRITE is never high for more than one cycle per transaction.
- rdata registers hold their value until the next read for the same requester.
- Requests arriving mid-transaction wait; they are never dropped while req is held.
- Fairness: with both requesting continuously, grants alternate LS, IF, LS, IF… (first tie after reset goes to LS).
- Reset mid-transaction: at the next edge return to IDLE and deassert all outputs. No ready pulse is issued for the aborted transaction; any write already presented in ACCESS stands.
- Address arithmetic is unsigned, ADDR_W wide; no wrap handling in the arbiter.

Optional Feature:
- Macro: ROM_BUS_ARB_RANGE_CHECK_EN.
- When defined:
  - Adds outputs if_err and ls_err (1 bit each, reset 0).
  - In IDLE the granted address is checked against the legal window.
  - An out-of-range request skips ACCESS (HWRITE stays 0, memory is untouched) and goes IDLE -> RESP.
  - In RESP, ready and err pulse together; rdata is unchanged.
- When undefined: no err ports, no check; every request performs ACCESS.

Test Plan:
- Reset: assert HRESET 2 cycles -> all outputs 0, busy 0. Then IF read at 0x10 -> HADDR=0x10 in cycle 2, if_ready pulse in cycle 3, if_rdata = HRDATA value (e.g. 0x13121110).
- LS write 0x20, wdata 0xDEADBEEF -> HWRITE=1 for exactly one cycle with HADDR=0x20, HWDATA=0xDEADBEEF. ls_ready pulses, ls_rdata unchanged. A following LS read at 0x20 returns 0xDEADBEEF.
- Simultaneous requests held for 4 transactions -> grant order LS, IF, LS, IF; each ready is a single-cycle pulse spaced 3 cycles apart.
- HRESET asserted during ACCESS of an IF read -> next cycle IDLE, if_ready never pulses, HWRITE 0.
- With ROM_BUS_ARB_RANGE_CHECK_EN: LS write at 0xFC (ROM_SIZE=256) -> HWRITE stays 0, ls_ready and ls_err pulse in cycle 2. IF read at 0xFB -> normal access, if_err 0.
